// File: rtl/fft_sample_loader_pkg.sv
// -----------------------------------------------------------------------------
// fft_sample_loader_pkg
//   Shared definitions for the FFT sample loader: default frame geometry, the
//   loader state encoding and the bit-reversal helper used for DIT ordering.
//   No ports (package).
// -----------------------------------------------------------------------------
package fft_sample_loader_pkg;

    localparam int unsigned FFT_LD_MEMWIDTH  = 32;  // sample words per frame
    localparam int unsigned FFT_LD_WORDWIDTH = 16;  // significant bits per sample

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GAP,
        SNAP,
        DONE
    } fft_ld_state_t;

    // Reverse the low 'width' bits of n; bits above 'width' come back zero.
    function automatic logic [31:0] bitrev(input logic [31:0] n, input int unsigned width);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < width; i++) begin
            r[5'(i)] = n[5'(width - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sample_loader_if.sv
// -----------------------------------------------------------------------------
// fft_sample_loader_if
//   Bundles the sample stream (valid/ready/data) and the RAM word-write bus.
//   slave  : loader view (consumes the stream, drives the RAM bus)
//   master : environment view (drives the stream, observes the RAM bus)
//   Signals: s_valid_i, s_ready_o, s_data_i[31:0],
//            mem_en_o, mem_we_o, mem_addr_o[$clog2(MEMWIDTH)-1:0], mem_data_o[31:0]
// -----------------------------------------------------------------------------
interface fft_sample_loader_if
    import fft_sample_loader_pkg::*;
#(
    parameter int unsigned MEMWIDTH = FFT_LD_MEMWIDTH
);

    localparam int unsigned ADDR_W = $clog2(MEMWIDTH);

    logic              s_valid_i;
    logic              s_ready_o;
    logic [31:0]       s_data_i;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_data_o;

    modport slave (
        input  s_valid_i, s_data_i,
        output s_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_data_o
    );

    modport master (
        output s_valid_i, s_data_i,
        input  s_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_data_o
    );

endinterface

// File: rtl/fft_addr_gen.sv
// -----------------------------------------------------------------------------
// fft_addr_gen
//   Sample counter and RAM address generator for the FFT sample loader.
//   Ports:
//     clk, rst   clock; asynchronous active-low reset
//     clr_i      clear the counter (takes priority over inc_i)
//     inc_i      count one accepted sample (saturates at MEMWIDTH)
//     cnt_o      samples accepted so far, 0..MEMWIDTH
//     full_o     last sample of the frame has been taken
//     addr_o     RAM address for the next sample
//   Build option: FFT_LOADER_BITREV_EN -> addr_o is the bit-reversed count
//   (in-place radix-2 DIT ordering); otherwise addr_o is the linear count.
// -----------------------------------------------------------------------------
module fft_addr_gen
    import fft_sample_loader_pkg::*;
#(
    parameter  int unsigned MEMWIDTH = FFT_LD_MEMWIDTH,
    localparam int unsigned ADDR_W   = $clog2(MEMWIDTH),
    localparam int unsigned CNT_W    = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              full_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !full_o) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // MEMWIDTH is a power of two, so the top bit alone marks a full frame.
    assign full_o = cnt_q[ADDR_W];
    assign cnt_o  = cnt_q;

`ifdef FFT_LOADER_BITREV_EN
    assign addr_o = ADDR_W'(bitrev(32'(cnt_q[ADDR_W-1:0]), ADDR_W));
`else
    assign addr_o = cnt_q[ADDR_W-1:0];
`endif

endmodule

// File: rtl/fft_sample_loader.sv
// -----------------------------------------------------------------------------
// fft_sample_loader
//   Upstream feeder for the FFT sample RAM. Takes MEMWIDTH samples from a
//   valid/ready stream, writes them one word per cycle, then issues a single
//   parallel-read strobe (en=1, we=0) and pulses frame_done_o.
//   Ports:
//     clk, rst       clock; asynchronous active-low reset
//     start_i        frame start, honoured only in IDLE
//     abort_i        drop the current frame (LOAD/GAP/SNAP)
//     bus            fft_sample_loader_if.slave: stream in, RAM write bus out
//     busy_o         high in every state but IDLE
//     frame_done_o   one-cycle pulse once the frame is latched
//     sample_cnt_o   samples accepted in the current frame
//   Build option: FFT_LOADER_BITREV_EN selects bit-reversed RAM addressing.
// -----------------------------------------------------------------------------
module fft_sample_loader
    import fft_sample_loader_pkg::*;
#(
    parameter int unsigned MEMWIDTH  = FFT_LD_MEMWIDTH,
    parameter int unsigned WORDWIDTH = FFT_LD_WORDWIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      abort_i,
    fft_sample_loader_if.slave        bus,
    output logic                      busy_o,
    output logic                      frame_done_o,
    output logic [$clog2(MEMWIDTH):0] sample_cnt_o
);

    localparam int unsigned ADDR_W = $clog2(MEMWIDTH);
    localparam logic [31:0] DATA_MASK =
        (WORDWIDTH >= 32) ? '1 : 32'((64'd1 << WORDWIDTH) - 64'd1);

    fft_ld_state_t     state_q, state_d;
    logic              ready_c;
    logic              hs;
    logic              wr;
    logic              cnt_clr;
    logic              cnt_full;
    logic [ADDR_W-1:0] cnt_addr;

    logic              en_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;

    assign hs      = ready_c && bus.s_valid_i;
    assign wr      = hs && !abort_i;           // abort wins over a same-cycle sample
    assign cnt_clr = (state_q == IDLE && start_i) ||
                     (abort_i && (state_q inside {LOAD, GAP, SNAP}));

    fft_addr_gen #(
        .MEMWIDTH (MEMWIDTH)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .inc_i  (wr),
        .cnt_o  (sample_cnt_o),
        .full_o (cnt_full),
        .addr_o (cnt_addr)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. LOAD is left one cycle after the last handshake (the
    // counter is full, ready is low) so that cycle carries the final write
    // strobe; GAP then follows as the settle cycle before SNAP.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_i) state_d = LOAD;
            LOAD: begin
                if (abort_i)       state_d = IDLE;
                else if (cnt_full) state_d = GAP;
            end
            GAP:  state_d = abort_i ? IDLE : SNAP;
            SNAP: state_d = abort_i ? IDLE : DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready_c      = 1'b0;
        busy_o       = 1'b0;
        frame_done_o = 1'b0;
        unique case (state_q)
            IDLE: ;
            LOAD: begin
                busy_o  = 1'b1;
                ready_c = !cnt_full;
            end
            GAP, SNAP: busy_o = 1'b1;
            DONE: begin
                busy_o       = 1'b1;
                frame_done_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered RAM bus. The SNAP read strobe is registered from the
    // next state so it lines up with the SNAP cycle itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q   <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            en_q <= wr || (state_d == SNAP);
            we_q <= wr;
            if (wr) begin
                addr_q <= cnt_addr;
                data_q <= bus.s_data_i & DATA_MASK;
            end
        end
    end

    assign bus.s_ready_o  = ready_c;
    assign bus.mem_en_o   = en_q;
    assign bus.mem_we_o   = we_q;
    assign bus.mem_addr_o = addr_q;
    assign bus.mem_data_o = data_q;

endmodule
